// File: rtl/uart_pkg.sv
// Shared encodings, state types and helpers for the parametrised framed UART.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4,
    RX_BREAK  = 3'd5,
    RX_ERROR  = 3'd6
  } rx_state_t;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

  // Clock cycles one transmitted frame occupies, first start-bit cycle to end of last stop bit.
  function automatic int frame_cycles(input int baudsel, input int data_bits,
                                      input int parity, input int stop_bits);
    return (2 * baudsel + 1) *
           (1 + data_bits + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits);
  endfunction

  function automatic logic parity_bit(input logic [8:0] data, input int parity);
    logic ones;
    ones = ^data;
    return (parity == PARITY_ODD) ? ~ones : ones;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter with preload; o_tick marks the cycle the count sits at 2*BAUDSEL,
// after which it wraps to zero.
module uart_bit_timer #(
  parameter int BAUDSEL = 10,
  parameter int CW      = $clog2(2 * BAUDSEL + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  output logic          o_tick
);

  localparam logic [CW-1:0] LAST = CW'(2 * BAUDSEL);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/uart_framed.sv
// Full-duplex UART with compile-time data width, optional parity, 1/2 stop bits,
// per-byte error reporting and break detection/generation.
module uart_framed
  import uart_pkg::*;
#(
  parameter int BAUDSEL   = 10,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic                 tx,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  input  logic                 tx_break,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_perr,
  input  logic                 rx_ready,
  output logic                 rx_ferr,
  output logic                 rx_overrun,
  output logic                 rx_break
);

  localparam int         CW        = $clog2(2 * BAUDSEL + 1);
  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);
  localparam bit         HAS_PAR   = (PARITY != PARITY_NONE);

  logic r_rx_meta;
  logic r_rx_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  rx_state_t            r_rx_state;
  logic [DATA_BITS-1:0] r_rx_shift;
  logic [3:0]           r_rx_bitcnt;
  logic                 r_rx_stopcnt;
  logic                 r_rx_xor;
  logic                 r_rx_any;
  logic                 r_rx_valid;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_perr;
  logic                 r_rx_ferr;
  logic                 r_rx_overrun;
  logic                 r_rx_break;
  logic                 w_rx_tick;
  logic                 w_rx_load;
  logic                 w_rx_perr;

  // Preloading to BAUDSEL on the falling edge puts every later sample mid-bit.
  assign w_rx_load = (r_rx_state == RX_IDLE) && !r_rx_s;
  assign w_rx_perr = (PARITY == PARITY_ODD)  ? !r_rx_xor :
                     (PARITY == PARITY_EVEN) ?  r_rx_xor : 1'b0;

  uart_bit_timer #(
    .BAUDSEL (BAUDSEL),
    .CW      (CW)
  ) u_rx_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_rx_load),
    .i_load_val (CW'(BAUDSEL)),
    .o_tick     (w_rx_tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_state   <= RX_IDLE;
      r_rx_shift   <= '0;
      r_rx_bitcnt  <= 4'd0;
      r_rx_stopcnt <= 1'b0;
      r_rx_xor     <= 1'b0;
      r_rx_any     <= 1'b0;
      r_rx_valid   <= 1'b0;
      r_rx_data    <= '0;
      r_rx_perr    <= 1'b0;
      r_rx_ferr    <= 1'b0;
      r_rx_overrun <= 1'b0;
      r_rx_break   <= 1'b0;
    end else begin
      r_rx_ferr    <= 1'b0;
      r_rx_overrun <= 1'b0;
      r_rx_break   <= 1'b0;
      if (r_rx_valid && rx_ready) begin
        r_rx_valid <= 1'b0;
      end
      case (r_rx_state)
        RX_IDLE: begin
          if (!r_rx_s) begin
            r_rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (w_rx_tick) begin
            if (r_rx_s) begin
              r_rx_state <= RX_IDLE;
            end else begin
              r_rx_state  <= RX_DATA;
              r_rx_bitcnt <= 4'd0;
              r_rx_xor    <= 1'b0;
              r_rx_any    <= 1'b0;
            end
          end
        end
        RX_DATA: begin
          if (w_rx_tick) begin
            r_rx_shift <= {r_rx_s, r_rx_shift[DATA_BITS-1:1]};
            r_rx_xor   <= r_rx_xor ^ r_rx_s;
            r_rx_any   <= r_rx_any | r_rx_s;
            if (r_rx_bitcnt == LAST_DATA) begin
              r_rx_state   <= HAS_PAR ? RX_PARITY : RX_STOP;
              r_rx_stopcnt <= 1'b0;
            end else begin
              r_rx_bitcnt <= r_rx_bitcnt + 4'd1;
            end
          end
        end
        RX_PARITY: begin
          if (w_rx_tick) begin
            r_rx_xor     <= r_rx_xor ^ r_rx_s;
            r_rx_any     <= r_rx_any | r_rx_s;
            r_rx_state   <= RX_STOP;
            r_rx_stopcnt <= 1'b0;
          end
        end
        RX_STOP: begin
          if (w_rx_tick) begin
            if (!r_rx_s) begin
              if (!r_rx_any) begin
                r_rx_state <= RX_BREAK;
              end else begin
                r_rx_state <= RX_ERROR;
                r_rx_ferr  <= 1'b1;
              end
            end else if (r_rx_stopcnt == LAST_STOP) begin
              r_rx_state <= RX_IDLE;
              // A consumer taking the old byte this cycle frees the slot for the new one.
              if (!r_rx_valid || rx_ready) begin
                r_rx_valid <= 1'b1;
                r_rx_data  <= r_rx_shift;
                r_rx_perr  <= w_rx_perr;
              end else begin
                r_rx_overrun <= 1'b1;
              end
            end else begin
              r_rx_stopcnt <= 1'b1;
            end
          end
        end
        RX_BREAK: begin
          if (w_rx_tick && r_rx_s) begin
            r_rx_state <= RX_IDLE;
            r_rx_break <= 1'b1;
          end
        end
        RX_ERROR: begin
          if (w_rx_tick && r_rx_s) begin
            r_rx_state <= RX_IDLE;
          end
        end
        default: begin
          r_rx_state <= RX_IDLE;
        end
      endcase
    end
  end

  tx_state_t            r_tx_state;
  logic [DATA_BITS-1:0] r_tx_shift;
  logic                 r_tx_par;
  logic [3:0]           r_tx_bitcnt;
  logic                 r_tx_stopcnt;
  logic                 r_tx;
  logic                 w_tx_accept;
  logic                 w_tx_tick;

  assign tx_ready    = (r_tx_state == TX_IDLE) && !tx_break;
  assign w_tx_accept = tx_valid && tx_ready;

  uart_bit_timer #(
    .BAUDSEL (BAUDSEL),
    .CW      (CW)
  ) u_tx_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_tx_accept),
    .i_load_val ('0),
    .o_tick     (w_tx_tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_state   <= TX_IDLE;
      r_tx_shift   <= '0;
      r_tx_par     <= 1'b0;
      r_tx_bitcnt  <= 4'd0;
      r_tx_stopcnt <= 1'b0;
      r_tx         <= 1'b1;
    end else begin
      case (r_tx_state)
        TX_IDLE: begin
          if (w_tx_accept) begin
            r_tx_shift <= tx_data;
            r_tx_par   <= parity_bit(9'(tx_data), PARITY);
            r_tx       <= 1'b0;
            r_tx_state <= TX_START;
          end else begin
            r_tx <= !tx_break;
          end
        end
        TX_START: begin
          if (w_tx_tick) begin
            r_tx        <= r_tx_shift[0];
            r_tx_shift  <= {1'b0, r_tx_shift[DATA_BITS-1:1]};
            r_tx_bitcnt <= 4'd0;
            r_tx_state  <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (w_tx_tick) begin
            if (r_tx_bitcnt == LAST_DATA) begin
              r_tx_stopcnt <= 1'b0;
              if (HAS_PAR) begin
                r_tx       <= r_tx_par;
                r_tx_state <= TX_PARITY;
              end else begin
                r_tx       <= 1'b1;
                r_tx_state <= TX_STOP;
              end
            end else begin
              r_tx        <= r_tx_shift[0];
              r_tx_shift  <= {1'b0, r_tx_shift[DATA_BITS-1:1]};
              r_tx_bitcnt <= r_tx_bitcnt + 4'd1;
            end
          end
        end
        TX_PARITY: begin
          if (w_tx_tick) begin
            r_tx         <= 1'b1;
            r_tx_stopcnt <= 1'b0;
            r_tx_state   <= TX_STOP;
          end
        end
        TX_STOP: begin
          if (w_tx_tick) begin
            if (r_tx_stopcnt == LAST_STOP) begin
              r_tx_state <= TX_IDLE;
            end else begin
              r_tx_stopcnt <= 1'b1;
            end
          end
        end
        default: begin
          r_tx_state <= TX_IDLE;
          r_tx       <= 1'b1;
        end
      endcase
    end
  end

  assign tx         = r_tx;
  assign rx_valid   = r_rx_valid;
  assign rx_data    = r_rx_data;
  assign rx_perr    = r_rx_perr;
  assign rx_ferr    = r_rx_ferr;
  assign rx_overrun = r_rx_overrun;
  assign rx_break   = r_rx_break;

endmodule

// File: tb/tb_uart_framed.sv
// Self-checking bench: an 8N1 instance (TX waveform, loopback, errors, break) and a
// 7E2 instance (parity), both against a frame model built from the line-format rules.
module tb_uart_framed;

  localparam int BAUD = 2;
  localparam int P    = 2 * BAUD + 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       a_rx_drv = 1'b1, a_loop = 1'b0, a_rx_in;
  logic       a_tx, a_tx_valid = 1'b0, a_tx_ready, a_tx_break = 1'b0;
  logic [7:0] a_tx_data = 8'h00, a_rx_data;
  logic       a_rx_valid, a_rx_perr, a_rx_ready = 1'b0, a_rx_ferr, a_rx_ovr, a_rx_brk;
  assign a_rx_in = a_loop ? a_tx : a_rx_drv;

  logic       b_rx = 1'b1, b_tx, b_tx_ready, b_rx_valid, b_rx_perr, b_rx_ready = 1'b0;
  logic       b_rx_ferr, b_rx_ovr, b_rx_brk;
  logic [6:0] b_tx_data = 7'h00, b_rx_data;
  logic       b_tx_valid = 1'b0, b_tx_break = 1'b0;

  uart_framed #(.BAUDSEL(BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut_a (
    .clk(clk), .reset(reset), .rx(a_rx_in), .tx(a_tx), .tx_valid(a_tx_valid),
    .tx_data(a_tx_data), .tx_ready(a_tx_ready), .tx_break(a_tx_break),
    .rx_valid(a_rx_valid), .rx_data(a_rx_data), .rx_perr(a_rx_perr),
    .rx_ready(a_rx_ready), .rx_ferr(a_rx_ferr), .rx_overrun(a_rx_ovr), .rx_break(a_rx_brk));

  uart_framed #(.BAUDSEL(BAUD), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_dut_b (
    .clk(clk), .reset(reset), .rx(b_rx), .tx(b_tx), .tx_valid(b_tx_valid),
    .tx_data(b_tx_data), .tx_ready(b_tx_ready), .tx_break(b_tx_break),
    .rx_valid(b_rx_valid), .rx_data(b_rx_data), .rx_perr(b_rx_perr),
    .rx_ready(b_rx_ready), .rx_ferr(b_rx_ferr), .rx_overrun(b_rx_ovr), .rx_break(b_rx_brk));

  int n_vec = 0;
  int n_err = 0;
  int a_ferr_n = 0, a_ovr_n = 0, a_brk_n = 0, a_dlv_n = 0;
  logic a_prev_v = 1'b0;
  bit frame_q[$];

  // Event counters for the 8N1 receiver, sampled mid-cycle.
  always @(negedge clk) begin
    if (a_rx_ferr) a_ferr_n <= a_ferr_n + 1;
    if (a_rx_ovr)  a_ovr_n  <= a_ovr_n + 1;
    if (a_rx_brk)  a_brk_n  <= a_brk_n + 1;
    if (a_rx_valid && !a_prev_v) a_dlv_n <= a_dlv_n + 1;
    a_prev_v <= a_rx_valid;
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Line levels of one frame: start, data LSB first, optional parity, stop bits.
  task automatic build_frame(input int data, input int nd, input int par, input int nstop,
                             input bit flip_par, input bit bad_stop);
    int ones;
    bit pb;
    frame_q.delete();
    frame_q.push_back(1'b0);
    ones = 0;
    for (int i = 0; i < nd; i++) begin
      frame_q.push_back(bit'((data >> i) & 1));
      ones += (data >> i) & 1;
    end
    if (par != 0) begin
      pb = (par == 2) ? bit'(ones % 2) : bit'(1 - (ones % 2));
      frame_q.push_back(pb ^ flip_par);
    end
    for (int s = 0; s < nstop; s++) frame_q.push_back(bad_stop ? 1'b0 : 1'b1);
  endtask

  task automatic play_frame(input bit to_b);
    foreach (frame_q[i]) begin
      if (to_b) b_rx = frame_q[i];
      else a_rx_drv = frame_q[i];
      cycles(P);
    end
    if (to_b) b_rx = 1'b1;
    else a_rx_drv = 1'b1;
  endtask

  task automatic wait_valid(input bit on_b, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ((on_b ? b_rx_valid : a_rx_valid) === 1'b1) begin
        ok = 1'b1;
        break;
      end
      cycles(1);
    end
  endtask

  task automatic test_reset();
    cycles(4);
    n_vec += 8;
    if (a_tx !== 1'b1)       begin n_err++; $display("FAIL reset_tx: got %b want 1", a_tx); end
    if (a_rx_valid !== 1'b0) begin n_err++; $display("FAIL reset_rx_valid: got %b want 0", a_rx_valid); end
    if (a_rx_perr !== 1'b0)  begin n_err++; $display("FAIL reset_perr: got %b want 0", a_rx_perr); end
    if (a_rx_ferr !== 1'b0)  begin n_err++; $display("FAIL reset_ferr: got %b want 0", a_rx_ferr); end
    if (a_rx_ovr !== 1'b0)   begin n_err++; $display("FAIL reset_overrun: got %b want 0", a_rx_ovr); end
    if (a_rx_brk !== 1'b0)   begin n_err++; $display("FAIL reset_break: got %b want 0", a_rx_brk); end
    if (b_tx !== 1'b1)       begin n_err++; $display("FAIL reset_b_tx: got %b want 1", b_tx); end
    if (b_rx_valid !== 1'b0) begin n_err++; $display("FAIL reset_b_rx_valid: got %b want 0", b_rx_valid); end
    reset = 1'b0;
    cycles(2);
    n_vec++;
    if (a_tx_ready !== 1'b1) begin n_err++; $display("FAIL reset_tx_ready: got %b want 1", a_tx_ready); end
  endtask

  task automatic test_tx_waveform();
    int wave_err, low_cnt;
    build_frame(32'hA5, 8, 0, 1, 1'b0, 1'b0);
    a_tx_data = 8'hA5;
    a_tx_valid = 1'b1;
    cycles(1);
    a_tx_valid = 1'b0;
    wave_err = 0;
    low_cnt = 0;
    for (int k = 0; k < frame_q.size() * P; k++) begin
      if (a_tx !== frame_q[k / P]) wave_err++;
      if (a_tx_ready !== 1'b1) low_cnt++;
      cycles(1);
    end
    n_vec += 4;
    if (wave_err != 0)       begin n_err++; $display("FAIL tx_wave: got %0d bad cycles want 0", wave_err); end
    if (low_cnt != 50)       begin n_err++; $display("FAIL tx_ready_low: got %0d cycles want 50", low_cnt); end
    if (a_tx_ready !== 1'b1) begin n_err++; $display("FAIL tx_ready_after: got %b want 1", a_tx_ready); end
    if (a_tx !== 1'b1)       begin n_err++; $display("FAIL tx_idle_after: got %b want 1", a_tx); end
  endtask

  task automatic test_loopback();
    logic [7:0] d;
    bit ok, sent;
    a_loop = 1'b1;
    for (int n = 0; n < 4; n++) begin
      d = (n == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
      sent = 1'b0;
      for (int i = 0; i < 200 && !sent; i++) begin
        if (a_tx_ready === 1'b1) begin
          a_tx_data = d;
          a_tx_valid = 1'b1;
          sent = 1'b1;
        end
        cycles(1);
      end
      a_tx_valid = 1'b0;
      wait_valid(1'b0, ok);
      n_vec += 3;
      if (!ok)                   begin n_err++; $display("FAIL loop_timeout: got no rx_valid want rx_valid (byte %0h)", d); end
      if (a_rx_data !== d)       begin n_err++; $display("FAIL loop_data: got %0h want %0h", a_rx_data, d); end
      if (a_rx_perr !== 1'b0)    begin n_err++; $display("FAIL loop_perr: got %b want 0", a_rx_perr); end
      a_rx_ready = 1'b1;
      cycles(1);
      a_rx_ready = 1'b0;
      n_vec++;
      if (a_rx_valid !== 1'b0)   begin n_err++; $display("FAIL loop_valid_drop: got %b want 0", a_rx_valid); end
    end
    cycles(3 * P);
    a_loop = 1'b0;
  endtask

  task automatic test_parity();
    int d;
    bit flip, ok;
    for (int n = 0; n < 4; n++) begin
      d = (n < 2) ? 32'h41 : int'($urandom_range(0, 127));
      flip = (n == 0) ? 1'b0 : (n == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      build_frame(d, 7, 2, 2, flip, 1'b0);
      play_frame(1'b1);
      cycles(P);
      wait_valid(1'b1, ok);
      n_vec += 3;
      if (!ok)                     begin n_err++; $display("FAIL par_timeout: got no rx_valid want rx_valid (data %0h)", d); end
      if (b_rx_data !== 7'(d))     begin n_err++; $display("FAIL par_data: got %0h want %0h", b_rx_data, d); end
      if (b_rx_perr !== flip)      begin n_err++; $display("FAIL par_perr: got %b want %b (data %0h)", b_rx_perr, flip, d); end
      b_rx_ready = 1'b1;
      cycles(1);
      b_rx_ready = 1'b0;
      n_vec++;
      if (b_rx_valid !== 1'b0)     begin n_err++; $display("FAIL par_valid_drop: got %b want 0", b_rx_valid); end
    end
  endtask

  task automatic test_framing();
    int f0, d0;
    bit ok;
    f0 = a_ferr_n;
    d0 = a_dlv_n;
    build_frame(32'h3C, 8, 0, 1, 1'b0, 1'b1);
    play_frame(1'b0);
    cycles(3 * P);
    n_vec += 3;
    if (a_ferr_n - f0 != 1)  begin n_err++; $display("FAIL ferr_pulses: got %0d want 1", a_ferr_n - f0); end
    if (a_dlv_n - d0 != 0)   begin n_err++; $display("FAIL ferr_delivered: got %0d want 0", a_dlv_n - d0); end
    if (a_rx_valid !== 1'b0) begin n_err++; $display("FAIL ferr_valid: got %b want 0", a_rx_valid); end
    build_frame(32'h55, 8, 0, 1, 1'b0, 1'b0);
    play_frame(1'b0);
    wait_valid(1'b0, ok);
    n_vec += 2;
    if (!ok)                 begin n_err++; $display("FAIL after_ferr_timeout: got no rx_valid want rx_valid"); end
    if (a_rx_data !== 8'h55) begin n_err++; $display("FAIL after_ferr_data: got %0h want 55", a_rx_data); end
    a_rx_ready = 1'b1;
    cycles(1);
    a_rx_ready = 1'b0;
    cycles(2 * P);
  endtask

  task automatic test_break();
    int b0, d0, f0;
    b0 = a_brk_n;
    d0 = a_dlv_n;
    f0 = a_ferr_n;
    a_rx_drv = 1'b0;
    cycles(3 * 10 * P);
    a_rx_drv = 1'b1;
    cycles(3 * P);
    n_vec += 3;
    if (a_brk_n - b0 != 1)  begin n_err++; $display("FAIL rx_break_pulses: got %0d want 1", a_brk_n - b0); end
    if (a_dlv_n - d0 != 0)  begin n_err++; $display("FAIL rx_break_delivered: got %0d want 0", a_dlv_n - d0); end
    if (a_ferr_n - f0 != 0) begin n_err++; $display("FAIL rx_break_ferr: got %0d want 0", a_ferr_n - f0); end
    a_tx_break = 1'b1;
    cycles(2);
    n_vec += 2;
    if (a_tx !== 1'b0)       begin n_err++; $display("FAIL tx_break_line: got %b want 0", a_tx); end
    if (a_tx_ready !== 1'b0) begin n_err++; $display("FAIL tx_break_ready: got %b want 0", a_tx_ready); end
    cycles(20);
    n_vec++;
    if (a_tx !== 1'b0)       begin n_err++; $display("FAIL tx_break_hold: got %b want 0", a_tx); end
    a_tx_break = 1'b0;
    cycles(2);
    n_vec += 2;
    if (a_tx !== 1'b1)       begin n_err++; $display("FAIL tx_break_release: got %b want 1", a_tx); end
    if (a_tx_ready !== 1'b1) begin n_err++; $display("FAIL tx_break_release_ready: got %b want 1", a_tx_ready); end
  endtask

  task automatic test_overrun();
    int o0;
    o0 = a_ovr_n;
    build_frame(32'h11, 8, 0, 1, 1'b0, 1'b0);
    play_frame(1'b0);
    build_frame(32'h22, 8, 0, 1, 1'b0, 1'b0);
    play_frame(1'b0);
    cycles(2 * P);
    n_vec += 3;
    if (a_rx_valid !== 1'b1) begin n_err++; $display("FAIL ovr_valid: got %b want 1", a_rx_valid); end
    if (a_rx_data !== 8'h11) begin n_err++; $display("FAIL ovr_data: got %0h want 11", a_rx_data); end
    if (a_ovr_n - o0 != 1)   begin n_err++; $display("FAIL ovr_pulses: got %0d want 1", a_ovr_n - o0); end
    a_rx_ready = 1'b1;
    cycles(1);
    a_rx_ready = 1'b0;
    n_vec++;
    if (a_rx_valid !== 1'b0) begin n_err++; $display("FAIL ovr_valid_drop: got %b want 0", a_rx_valid); end
  endtask

  task automatic test_glitch();
    int d0, f0, b0, o0;
    d0 = a_dlv_n; f0 = a_ferr_n; b0 = a_brk_n; o0 = a_ovr_n;
    a_rx_drv = 1'b0;
    cycles(1);
    a_rx_drv = 1'b1;
    cycles(4 * P);
    n_vec += 4;
    if (a_dlv_n - d0 != 0)   begin n_err++; $display("FAIL glitch_delivered: got %0d want 0", a_dlv_n - d0); end
    if (a_ferr_n - f0 != 0)  begin n_err++; $display("FAIL glitch_ferr: got %0d want 0", a_ferr_n - f0); end
    if (a_brk_n - b0 != 0)   begin n_err++; $display("FAIL glitch_break: got %0d want 0", a_brk_n - b0); end
    if (a_ovr_n - o0 != 0)   begin n_err++; $display("FAIL glitch_overrun: got %0d want 0", a_ovr_n - o0); end
    build_frame(32'h96, 8, 0, 1, 1'b0, 1'b0);
    play_frame(1'b0);
    cycles(P);
    n_vec++;
    if (a_rx_data !== 8'h96 || a_rx_valid !== 1'b1) begin
      n_err++; $display("FAIL glitch_next_byte: got %0h/%b want 96/1", a_rx_data, a_rx_valid);
    end
    a_rx_ready = 1'b1;
    cycles(1);
    a_rx_ready = 1'b0;
  endtask

  task automatic test_reset_mid_tx();
    a_tx_data = 8'($urandom_range(0, 255));
    a_tx_valid = 1'b1;
    cycles(1);
    a_tx_valid = 1'b0;
    cycles(17);
    reset = 1'b1;
    cycles(1);
    n_vec += 2;
    if (a_tx !== 1'b1)       begin n_err++; $display("FAIL midreset_tx: got %b want 1", a_tx); end
    if (a_tx_ready !== 1'b1) begin n_err++; $display("FAIL midreset_ready: got %b want 1", a_tx_ready); end
    reset = 1'b0;
    cycles(3 * P);
    n_vec += 2;
    if (a_tx !== 1'b1)       begin n_err++; $display("FAIL midreset_tx_after: got %b want 1", a_tx); end
    if (a_rx_valid !== 1'b0) begin n_err++; $display("FAIL midreset_rx_valid: got %b want 0", a_rx_valid); end
  endtask

  initial begin
    test_reset();
    test_tx_waveform();
    test_loopback();
    test_parity();
    test_framing();
    test_break();
    test_overrun();
    test_glitch();
    test_reset_mid_tx();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
